// File: rtl/fa_serial_adder_ctrl.sv
// fa_serial_adder_ctrl: bit-serial adder sequencer. A single FA cell adds
// the operands LSB-first, one bit per clock, and a carry register links
// the bits. The result appears on sum/cout together with a one-cycle
// done pulse.

// Single-bit full adder cell.
module FA (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (c & (a ^ b));

endmodule

module fa_serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] acc_sr;
    logic [WIDTH-1:0] acc_next;
    logic             carry_q;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_c;

    FA u_fa (
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .c     (carry_q),
        .sum   (fa_s),
        .carry (fa_c)
    );

    // With a single bit there are no older accumulator bits to shift down.
    generate
        if (WIDTH == 1) begin : g_acc1
            assign acc_next = fa_s;
        end else begin : g_accn
            assign acc_next = {fa_s, acc_sr[WIDTH-1:1]};
        end
    endgenerate

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    // Sequencer: capture operands, shift one bit per RUN cycle, publish result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            a_sr    <= '0;
            b_sr    <= '0;
            acc_sr  <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sr    <= a;
                        b_sr    <= b;
                        carry_q <= cin;
                        cnt     <= '0;
                        state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc_sr  <= acc_next;
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    carry_q <= fa_c;
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        sum   <= acc_next;
                        cout  <= fa_c;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fa_serial_adder_ctrl.sv
// Directed bench for fa_serial_adder_ctrl at WIDTH=8 and WIDTH=1.
module tb_fa_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       cin8 = 1'b0;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       cout8;

    logic       start1 = 1'b0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       cin1 = 1'b0;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fa_serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    fa_serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full WIDTH=8 operation with 1-cycle start; inputs scrambled after E0.
    task automatic run8(input string tag, input logic [7:0] x, input logic [7:0] y,
                        input logic c, input logic [7:0] prev_s, input logic prev_c,
                        input logic [7:0] exp_s, input logic exp_c);
        a8 = x; b8 = y; cin8 = c; start8 = 1'b1;
        tick();                                   // E0
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        chk({tag, ".busy_e0"}, {31'd0, busy8}, 32'd1);
        for (int i = 1; i <= 7; i++) begin
            tick();                               // E1..E7
            chk({tag, ".run_bd"}, {30'd0, busy8, done8}, 32'b10);
            chk({tag, ".hold_sum"}, {23'd0, cout8, sum8}, {23'd0, prev_c, prev_s});
        end
        tick();                                   // E8
        chk({tag, ".done_bd"}, {30'd0, busy8, done8}, 32'b01);
        chk({tag, ".sum"}, {24'd0, sum8}, {24'd0, exp_s});
        chk({tag, ".cout"}, {31'd0, cout8}, {31'd0, exp_c});
        tick();                                   // E9
        chk({tag, ".idle_bd"}, {30'd0, busy8, done8}, 32'b00);
        chk({tag, ".sum_keep"}, {23'd0, cout8, sum8}, {23'd0, exp_c, exp_s});
    endtask

    task automatic run1(input string tag, input logic x, input logic y, input logic c,
                        input logic prev_s, input logic prev_c,
                        input logic exp_s, input logic exp_c);
        a1 = x; b1 = y; cin1 = c; start1 = 1'b1;
        tick();                                   // E0
        start1 = 1'b0; a1 = ~a1; b1 = ~b1; cin1 = ~cin1;
        chk({tag, ".busy"}, {30'd0, busy1, done1}, 32'b10);
        chk({tag, ".hold"}, {30'd0, cout1, sum1}, {30'd0, prev_c, prev_s});
        tick();                                   // E1
        chk({tag, ".done"}, {30'd0, busy1, done1}, 32'b01);
        chk({tag, ".result"}, {30'd0, cout1, sum1}, {30'd0, exp_c, exp_s});
        tick();
        chk({tag, ".idle"}, {30'd0, busy1, done1}, 32'b00);
    endtask

    initial begin
        int ndone;
        int last;
        logic [7:0] seen_s;
        logic seen_c;

        // Reset state
        #2;
        chk("rst.out8", {21'd0, busy8, done8, cout8, sum8}, 32'd0);
        chk("rst.out1", {28'd0, busy1, done1, cout1, sum1}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst.idle8", {30'd0, busy8, done8}, 32'd0);

        // Basic additions and boundaries
        run8("add5a3c", 8'h5A, 8'h3C, 1'b0, 8'h00, 1'b0, 8'h96, 1'b0);
        run8("addff01", 8'hFF, 8'h01, 1'b0, 8'h96, 1'b0, 8'h00, 1'b1);
        run8("addffff1", 8'hFF, 8'hFF, 1'b1, 8'h00, 1'b1, 8'hFF, 1'b1);

        // Start during RUN is ignored
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
        tick();                                   // E0
        start8 = 1'b0;
        tick();
        tick();                                   // E2
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
        tick();                                   // E3
        start8 = 1'b0;
        ndone = 0; seen_s = '0; seen_c = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8) begin
                ndone++;
                seen_s = sum8;
                seen_c = cout8;
            end
        end
        chk("ign.ndone", ndone, 32'd1);
        chk("ign.sum", {23'd0, seen_c, seen_s}, 32'h046);

        // Reset mid-operation
        a8 = 8'h77; b8 = 8'h11; cin8 = 1'b0; start8 = 1'b1;
        tick();                                   // E0
        start8 = 1'b0;
        tick();
        tick();
        tick();                                   // E3
        chk("mrst.busy_pre", {31'd0, busy8}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mrst.clear", {21'd0, busy8, done8, cout8, sum8}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8 || busy8) ndone++;
        end
        chk("mrst.nodone", ndone, 32'd0);
        run8("post_rst", 8'h01, 8'h01, 1'b0, 8'h00, 1'b0, 8'h02, 1'b0);

        // Start held high: back-to-back operations
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        ndone = 0; last = -1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done8) begin
                ndone++;
                chk("hold.sum", {23'd0, cout8, sum8}, 32'h030);
                if (last >= 0) chk("hold.period", i - last, 32'd10);
                last = i;
            end
        end
        start8 = 1'b0;
        chk("hold.ndone", ndone, 32'd3);
        tick();
        tick();

        // WIDTH=1 instance
        run1("w1_111", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        run1("w1_000", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
